regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined CPU core. It replaces the single-cycle register file and adds the following:
- configurable width and depth;
- a hard-wired zero register;
- write-to-read bypass;
- a per-register pending-write scoreboard for hazard detection;
- a registered, sticky halt flag raised by ECALL when the halt register holds the halt code.

It sits between the decode stage (reads and issue) and the writeback stage (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, at least 4
AW, $clog2(NREGS), register index width (derived, not overridable)
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h2ffc, reset value of the stack-pointer register
HALT_REG, 17, index of the register examined on ECALL
HALT_CODE, 10, value of HALT_REG that halts the core
BYPASS_EN, 1, 1 = forward the same-cycle writeback to the read ports

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rs1  in  AW  read index, port 1
rs2  in  AW  read index, port 2
rs1_dout  out  XLEN  read data, port 1 (combinational)
rs2_dout  out  XLEN  read data, port 2 (combinational)
rs1_busy  out  1  register rs1 has a pending write
rs2_busy  out  1  register rs2 has a pending write
issue_valid  in  1  decode issues an instruction this cycle
issue_rd  in  AW  destination of the issued instruction
issue_wr  in  1  issued instruction writes issue_rd
write_enable  in  1  writeback strobe (RegWrite)
rd  in  AW  writeback destination
rd_din  in  XLEN  writeback data
is_ecall  in  1  decode holds an ECALL this cycle
ecall_stall  out  1  ECALL cannot resolve; HALT_REG is pending
is_halted  out  1  sticky halt flag (registered)

Behaviour:
- Reset (synchronous, highest priority at the edge):
  - all registers clear to 0, except register SP_IDX, which loads SP_INIT;
  - the busy vector clears to all zeros;
  - is_halted clears to 0;
  - a reset asserted mid-operation discards any same-cycle write, issue or ECALL.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - its busy bit is never set.
- Read (combinational, zero latency):
  - dout = 0 when rs == 0;
  - otherwise, when BYPASS_EN && write_enable && rd == rs, dout = rd_din;
  - otherwise dout = the stored value.
- Write:
  - occurs at the edge when write_enable && rd != 0 && !is_halted;
  - once halted, all writes are blocked.
- Scoreboard, per register:
  - set when issue_valid && issue_wr && issue_rd == i && i != 0;
  - clear when write_enable && rd == i.
  - Set and clear of the same register in the same cycle: set wins, so the newer writer stays pending.
  - Setting an already-busy bit keeps it at 1. No counting: the pipeline guarantees one outstanding writer per register.
- rsN_busy:
  - = busy[rsN] && !(BYPASS_EN && write_enable && rd == rsN);
  - a writeback in progress resolves the hazard;
  - always 0 for index 0.
- Halt:
  - eff17 = the value of HALT_REG as seen through the bypass rule above.
  - ecall_stall = is_ecall && HALT_REG busy, using the same bypass masking as rsN_busy.
  - is_halted sets at the next edge when is_ecall && !ecall_stall && eff17 == HALT_CODE.
  - Once set, is_halted stays 1 until reset.
  - ECALL with any other value has no effect.
- Output reset values:
  - rs*_dout reflect the reset contents (0, and SP_INIT at SP_IDX);
  - busy outputs are 0;
  - is_halted is 0.

Decomposition:
- The shared CPU package holds:
  - the register-index constants: X0 = 0, SP = 2, A7 = 17;
  - the ECALL halt code (10);
  - the stack-pointer reset value;
  - the XLEN default.
- One sub-module is natural: regfile_scoreboard_sb. It holds the NREGS-bit busy vector, the set/clear logic and the masked busy lookup. Storage, bypass and halt logic stay in the top module.

Test Plan:
- Reset, then read every index → x2 = 32'h2ffc, all others 0; all busy outputs 0; is_halted = 0.
- Write x5 = 32'hdeadbeef with rs1 = 5 in the same cycle → rs1_dout = 32'hdeadbeef combinationally; after the edge it is still 32'hdeadbeef. Write x0 = 32'h1234 → x0 reads 0.
- Issue with rd = 7, then read rs2 = 7 → rs2_busy = 1. The writeback to x7 in a later cycle drops rs2_busy in that cycle. Issue and writeback to x7 in the same cycle → busy stays 1.
- x17 = 10, is_ecall = 1 → is_halted = 1 after one edge. A subsequent write to x3 is ignored. Deassert is_ecall → is_halted stays 1. Reset → is_halted = 0.
- x17 = 9, ecall → no halt. x17 busy and ecall with no writeback → ecall_stall = 1, no halt. Writeback of x17 = 10 in the ECALL cycle → ecall_stall = 0, and is_halted = 1 next cycle.
- Reset asserted together with write_enable (rd = 4, data 32'h55) and issue_valid (rd = 4) → after the edge x4 = 0, busy[4] = 0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU constants used by the register file: register indices,
// the ECALL halt code and reset values.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEF = 32;

    localparam int X0 = 0;
    localparam int SP = 2;
    localparam int A7 = 17;

    localparam int          HALT_CODE_DEF = 10;
    localparam logic [31:0] SP_INIT_DEF   = 32'h0000_2ffc;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle of the register file: read ports, issue,
// writeback and ECALL signalling.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_dout;
    logic [XLEN-1:0] rs2_dout;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            write_enable;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_din;
    logic            is_ecall;
    logic            ecall_stall;
    logic            is_halted;

    modport master (
        output rs1, rs2, issue_valid, issue_rd, issue_wr,
               write_enable, rd, rd_din, is_ecall,
        input  rs1_dout, rs2_dout, rs1_busy, rs2_busy, ecall_stall, is_halted
    );

    modport slave (
        input  rs1, rs2, issue_valid, issue_rd, issue_wr,
               write_enable, rd, rd_din, is_ecall,
        output rs1_dout, rs2_dout, rs1_busy, rs2_busy, ecall_stall, is_halted
    );

endinterface

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on writeback, with lookups masked by a same-cycle writeback.
module regfile_scoreboard_sb
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_rd,
    input  logic          write_enable,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rs3,
    output logic          busy1,
    output logic          busy2,
    output logic          busy3
);

    localparam logic          BYP  = 1'(BYPASS_EN != 0);
    localparam logic [AW-1:0] X0_A = AW'(X0);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;

    // Next busy vector; an issue wins over a writeback so the newer writer stays pending
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_valid && issue_wr && (issue_rd == AW'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (write_enable && (rd == AW'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
        busy_next_s[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy1 = (rs1 != X0_A) && busy_r[rs1] && !(BYP && write_enable && (rd == rs1));
    assign busy2 = (rs2 != X0_A) && busy_r[rs2] && !(BYP && write_enable && (rd == rs2));
    assign busy3 = (rs3 != X0_A) && busy_r[rs3] && !(BYP && write_enable && (rd == rs3));

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with hard-wired x0, writeback bypass, pending-write
// scoreboard and a sticky ECALL halt flag.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              NREGS     = 32,
    parameter int              SP_IDX    = SP,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(SP_INIT_DEF),
    parameter int              HALT_REG  = A7,
    parameter int              HALT_CODE = HALT_CODE_DEF,
    parameter int              BYPASS_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);

    localparam int            AW     = $clog2(NREGS);
    localparam logic          BYP    = 1'(BYPASS_EN != 0);
    localparam logic [AW-1:0] X0_A   = AW'(X0);
    localparam logic [AW-1:0] HALT_A = AW'(HALT_REG);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            halted_r;

    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [XLEN-1:0] halt_val_s;
    logic            halt_busy_s;
    logic            ecall_stall_s;
    logic            halt_set_s;

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   idx,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   wr_idx,
        input logic [XLEN-1:0] wr_data
    );
        logic [XLEN-1:0] val;
        if (idx == X0_A) begin
            val = '0;
        end else if (BYP && we && (wr_idx == idx)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    regfile_scoreboard_sb #(
        .NREGS     (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (bus.issue_valid),
        .issue_wr     (bus.issue_wr),
        .issue_rd     (bus.issue_rd),
        .write_enable (bus.write_enable),
        .rd           (bus.rd),
        .rs1          (bus.rs1),
        .rs2          (bus.rs2),
        .rs3          (HALT_A),
        .busy1        (bus.rs1_busy),
        .busy2        (bus.rs2_busy),
        .busy3        (halt_busy_s)
    );

    // Read ports and ECALL resolution, all seen through the writeback bypass
    always_comb begin
        rs1_val_s     = read_port(bus.rs1, regs_r[bus.rs1], bus.write_enable, bus.rd, bus.rd_din);
        rs2_val_s     = read_port(bus.rs2, regs_r[bus.rs2], bus.write_enable, bus.rd, bus.rd_din);
        halt_val_s    = read_port(HALT_A, regs_r[HALT_A], bus.write_enable, bus.rd, bus.rd_din);
        ecall_stall_s = bus.is_ecall && halt_busy_s;
        halt_set_s    = bus.is_ecall && !halt_busy_s && (halt_val_s == XLEN'(HALT_CODE));
    end

    // Register storage and sticky halt flag; a halted core accepts no writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            halted_r <= 1'b0;
        end else begin
            if (bus.write_enable && (bus.rd != X0_A) && !halted_r) begin
                regs_r[bus.rd] <= bus.rd_din;
            end
            halted_r <= halted_r | halt_set_s;
        end
    end

    assign bus.rs1_dout    = rs1_val_s;
    assign bus.rs2_dout    = rs2_val_s;
    assign bus.ecall_stall = ecall_stall_s;
    assign bus.is_halted   = halted_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios then random traffic,
// checked against an array-based model of the register file.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        stall;
        logic        halted;
    } exp_t;

    exp_t exp_q [$];

    logic [31:0] mem  [NREGS];
    bit          pend [NREGS];
    bit          halted_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_reset;
    logic [4:0]  s_rs1, s_rs2, s_issue_rd, s_rd;
    logic        s_iv, s_iw, s_we, s_ecall;
    logic [31:0] s_din;

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mem[i]  = (i == SP) ? 32'h0000_2ffc : 32'h0;
            pend[i] = 1'b0;
        end
        halted_m = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (s_we && s_rd == idx) return s_din;
        return mem[idx];
    endfunction

    function automatic bit exp_busy(input logic [4:0] idx);
        return (idx != 5'd0) && pend[idx] && !(s_we && s_rd == idx);
    endfunction

    task automatic apply();
        reset            = s_reset;
        bus.rs1          = s_rs1;
        bus.rs2          = s_rs2;
        bus.issue_valid  = s_iv;
        bus.issue_wr     = s_iw;
        bus.issue_rd     = s_issue_rd;
        bus.write_enable = s_we;
        bus.rd           = s_rd;
        bus.rd_din       = s_din;
        bus.is_ecall     = s_ecall;
    endtask

    task automatic step();
        exp_t e;
        bit   hs;
        @(posedge clk);
        #1;
        apply();
        e.d1     = exp_read(s_rs1);
        e.d2     = exp_read(s_rs2);
        e.b1     = exp_busy(s_rs1);
        e.b2     = exp_busy(s_rs2);
        e.stall  = s_ecall && exp_busy(5'd17);
        e.halted = halted_m;
        exp_q.push_back(e);
        if (s_reset) begin
            model_reset();
        end else begin
            hs = s_ecall && !exp_busy(5'd17) && (exp_read(5'd17) == 32'd10);
            if (s_we && s_rd != 5'd0 && !halted_m) mem[s_rd] = s_din;
            for (int i = 1; i < NREGS; i++) begin
                if (s_iv && s_iw && s_issue_rd == 5'(i)) pend[i] = 1'b1;
                else if (s_we && s_rd == 5'(i)) pend[i] = 1'b0;
            end
            if (hs) halted_m = 1'b1;
        end
    endtask

    task automatic idle();
        s_reset = 1'b0;
        s_iv    = 1'b0;
        s_iw    = 1'b0;
        s_we    = 1'b0;
        s_ecall = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rs1_dout",    bus.rs1_dout,            e.d1);
            check("rs2_dout",    bus.rs2_dout,            e.d2);
            check("rs1_busy",    32'(bus.rs1_busy),       32'(e.b1));
            check("rs2_busy",    32'(bus.rs2_busy),       32'(e.b2));
            check("ecall_stall", 32'(bus.ecall_stall),    32'(e.stall));
            check("is_halted",   32'(bus.is_halted),      32'(e.halted));
        end
    end

    initial begin
        int wait_cycles;
        s_reset = 1'b1; s_rs1 = 5'd0; s_rs2 = 5'd0; s_issue_rd = 5'd0; s_rd = 5'd0;
        s_iv = 1'b0; s_iw = 1'b0; s_we = 1'b0; s_ecall = 1'b0; s_din = 32'h0;
        apply();
        model_reset();
        step();
        step();

        // reset contents of every index
        idle();
        for (int i = 0; i < 16; i++) begin
            s_rs1 = 5'(i);
            s_rs2 = 5'(i + 16);
            step();
        end

        // write with same-cycle read, then x0 write
        s_we = 1'b1; s_rd = 5'd5; s_din = 32'hdead_beef; s_rs1 = 5'd5; s_rs2 = 5'd2;
        step();
        idle(); step();
        s_we = 1'b1; s_rd = 5'd0; s_din = 32'h0000_1234; s_rs1 = 5'd0; s_rs2 = 5'd0;
        step();
        idle(); step();

        // scoreboard set, clear, and set-wins collision
        s_iv = 1'b1; s_iw = 1'b1; s_issue_rd = 5'd7; s_rs2 = 5'd7; s_rs1 = 5'd5;
        step();
        idle(); step();
        s_we = 1'b1; s_rd = 5'd7; s_din = 32'h0000_0077;
        step();
        idle(); step();
        s_iv = 1'b1; s_iw = 1'b1; s_issue_rd = 5'd7; s_we = 1'b1; s_rd = 5'd7; s_din = 32'h0000_0078;
        step();
        idle(); step();
        s_we = 1'b1; s_rd = 5'd7; s_din = 32'h0000_0079;
        step();

        // halt on x17 == 10, writes blocked afterwards
        idle(); s_we = 1'b1; s_rd = 5'd17; s_din = 32'd10; s_rs1 = 5'd17;
        step();
        idle(); s_ecall = 1'b1;
        step();
        idle(); s_we = 1'b1; s_rd = 5'd3; s_din = 32'h0000_0033; s_rs1 = 5'd3;
        step();
        idle(); step(); step();
        s_reset = 1'b1; step();
        idle(); step();

        // no halt on x17 == 9, stall while x17 pending, bypassed resolution
        s_we = 1'b1; s_rd = 5'd17; s_din = 32'd9; step();
        idle(); s_ecall = 1'b1; step();
        idle(); s_iv = 1'b1; s_iw = 1'b1; s_issue_rd = 5'd17; s_rs1 = 5'd17; step();
        idle(); s_ecall = 1'b1; step();
        idle(); s_ecall = 1'b1; s_we = 1'b1; s_rd = 5'd17; s_din = 32'd10; step();
        idle(); step();

        // reset discards same-cycle write and issue
        s_reset = 1'b1; s_we = 1'b1; s_rd = 5'd4; s_din = 32'h0000_0055;
        s_iv = 1'b1; s_iw = 1'b1; s_issue_rd = 5'd4; s_rs1 = 5'd4; s_rs2 = 5'd4;
        step();
        idle(); step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            s_reset    = ($urandom_range(0, 49) == 0);
            s_rs1      = ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
            s_rs2      = 5'($urandom_range(0, 31));
            s_iv       = 1'($urandom_range(0, 1));
            s_iw       = 1'($urandom_range(0, 1));
            s_issue_rd = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
            s_we       = 1'($urandom_range(0, 1));
            s_rd       = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
            s_din      = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom);
            s_ecall    = ($urandom_range(0, 7) == 0);
            step();
        end

        idle();
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
